// File: rtl/shake_arb_pkg.sv
// Shared types and constants for the SHAKE256 session arbiter.
package shake_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int unsigned FLUSH_CYCLES = 1;

  // last_len must encode 0..DATA_IN_BITS inclusive.
  function automatic int unsigned len_width(input int unsigned data_in_bits);
    return $clog2(data_in_bits) + 1;
  endfunction

endpackage

// File: rtl/shake_arbiter_rr_pick.sv
// Round-robin priority encoder: first set req scanning from last_owner+1 modulo NREQ.
module rr_pick #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_owner,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  assign any_req = |req;

  // Walk from lowest to highest priority so the closest set req overwrites last.
  always_comb begin
    winner = '0;
    for (int k = int'(NREQ); k >= 1; k--) begin
      if (req[(int'(last_owner) + k) % int'(NREQ)]) begin
        winner = IDX_W'((int'(last_owner) + k) % int'(NREQ));
      end
    end
  end

endmodule

// File: rtl/shake_arbiter.sv
// Shares one SHAKE256 core among NREQ samplers, granting whole sessions round-robin
// with a core flush between owners.
module shake_arbiter
  import shake_arb_pkg::*;
#(
  parameter int unsigned NREQ          = 3,
  parameter int unsigned DATA_IN_BITS  = 64,
  parameter int unsigned DATA_OUT_BITS = 64,
  parameter int unsigned LEN_W         = len_width(DATA_IN_BITS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req,
  output logic [NREQ-1:0]               grant,
  output logic                          busy,
  input  logic [NREQ-1:0]               r_force_rst,
  input  logic [NREQ*DATA_IN_BITS-1:0]  r_data_in,
  input  logic [NREQ-1:0]               r_in_valid,
  input  logic [NREQ-1:0]               r_in_last,
  input  logic [NREQ*LEN_W-1:0]         r_last_len,
  input  logic [NREQ-1:0]               r_out_ready,
  output logic [NREQ-1:0]               r_in_ready,
  output logic [NREQ-1:0]               r_out_valid,
  output logic [DATA_OUT_BITS-1:0]      r_data_out,
  output logic                          s_force_rst,
  output logic [DATA_IN_BITS-1:0]       s_data_in,
  output logic                          s_in_valid,
  output logic                          s_in_last,
  output logic [LEN_W-1:0]              s_last_len,
  output logic                          s_out_ready,
  input  logic                          s_in_ready,
  input  logic                          s_out_valid,
  input  logic [DATA_OUT_BITS-1:0]      s_data_out
);

  localparam int unsigned IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned FLUSH_W = $clog2(FLUSH_CYCLES + 1);

  state_t               state;
  logic [IDX_W-1:0]     last_owner;
  logic [FLUSH_W-1:0]   flush_cnt;
  logic [IDX_W-1:0]     winner;
  logic                 any_req;
  logic [NREQ-1:0]      winner_oh;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req        (req),
    .last_owner (last_owner),
    .winner     (winner),
    .any_req    (any_req)
  );

  assign winner_oh = NREQ'(1) << winner;

  // Session FSM: grant and owner pointer only change here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_owner <= IDX_W'(NREQ - 1);
      flush_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant      <= winner_oh;
            last_owner <= winner;
            state      <= OWN;
          end
        end
        OWN: begin
          if (!req[last_owner]) begin
            grant     <= '0;
            flush_cnt <= '0;
            state     <= FLUSH;
          end
        end
        FLUSH: begin
          if (flush_cnt == FLUSH_W'(FLUSH_CYCLES - 1)) begin
            state <= IDLE;
          end else begin
            flush_cnt <= FLUSH_W'(flush_cnt + 1'b1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign r_data_out = s_data_out;

  // Owner mux; with no grant everything toward the core is zero except the flush pulse.
  always_comb begin
    s_force_rst = (state == FLUSH);
    s_data_in   = '0;
    s_in_valid  = 1'b0;
    s_in_last   = 1'b0;
    s_last_len  = '0;
    s_out_ready = 1'b0;
    r_in_ready  = '0;
    r_out_valid = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant[i]) begin
        s_force_rst    = r_force_rst[i];
        s_data_in      = r_data_in[i*DATA_IN_BITS +: DATA_IN_BITS];
        s_in_valid     = r_in_valid[i];
        s_in_last      = r_in_last[i];
        s_last_len     = r_last_len[i*LEN_W +: LEN_W];
        s_out_ready    = r_out_ready[i];
        r_in_ready[i]  = s_in_ready;
        r_out_valid[i] = s_out_valid;
      end
    end
  end

endmodule
